// File: rtl/hist_pkg.sv
// Shared constants and types for the photon-timing histogram readout path.
// Also used by the histogram block for its counter type.
package hist_pkg;

  localparam int         NBINS     = 8;
  localparam int         NIPI      = 64;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [31:0] count_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_SEND,
    S_CSUM
  } state_t;

  // Sync + 2 count bytes + 4 bytes per word + checksum.
  function automatic int frame_len(input int nbins, input int nipi);
    return 4 + 4 * (nbins + nipi);
  endfunction

  localparam int FRAME_LEN = frame_len(NBINS, NIPI);

endpackage

// File: rtl/hist_byte_sel.sv
// Picks the snapshot byte carried at a given frame byte index (index 3 onward).
// Words are sent little-endian; indices outside the payload yield zero.
module hist_byte_sel
  import hist_pkg::*;
#(
  parameter int NWORDS = NBINS + NIPI,
  parameter int IDX_W  = $clog2(frame_len(NBINS, NIPI))
) (
  input  count_t           words_i [NWORDS],
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       byte_o
);

  localparam int WSEL_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [IDX_W-1:0]  off;
  logic [IDX_W-1:0]  word_full;
  logic [WSEL_W-1:0] word_sel;
  logic [1:0]        lane;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    byte_o    = 8'h00;
    off       = idx_i - IDX_W'(3);
    word_full = off >> 2;
    word_sel  = word_full[WSEL_W-1:0];
    lane      = off[1:0];
    if (idx_i >= IDX_W'(3) && word_full < IDX_W'(NWORDS)) begin
      byte_o = words_i[word_sel][{lane, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/hist_readout.sv
// Snapshots photon-bin and interval histograms on request and streams them
// as a framed, XOR-checksummed byte stream over a valid/ready byte link.
module hist_readout
  import hist_pkg::*;
#(
  parameter int         NBINS     = hist_pkg::NBINS,
  parameter int         NIPI      = hist_pkg::NIPI,
  parameter logic [7:0] SYNC_BYTE = hist_pkg::SYNC_BYTE
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                start,
  input  logic                clear_after,
  input  logic [32*NBINS-1:0] histo_in,
  input  logic [32*NIPI-1:0]  ipihist_in,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                resethist,
  output logic [15:0]         frame_count
);

  localparam int                NWORDS   = NBINS + NIPI;
  localparam int                FLEN     = frame_len(NBINS, NIPI);
  localparam int                IDX_W    = $clog2(FLEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FLEN - 2);

  state_t           state_q;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       tx_data_q;
  logic [7:0]       next_byte_d;
  logic [7:0]       sel_byte;
  logic             tx_valid_q;
  logic             resethist_q;
  logic [15:0]      frame_count_q;
  count_t           snap_q [NWORDS];

  // NOTE: the snapshot is pure datapath, fully rewritten in SNAP before any read, so it carries no reset.
  always_ff @(posedge clkin) begin
    if (state_q == S_SNAP) begin
      for (int i = 0; i < NBINS; i++) snap_q[i] <= histo_in[32*i +: 32];
      for (int j = 0; j < NIPI; j++) snap_q[NBINS+j] <= ipihist_in[32*j +: 32];
    end
  end

  hist_byte_sel #(
    .NWORDS(NWORDS),
    .IDX_W (IDX_W)
  ) u_byte_sel (
    .words_i(snap_q),
    .idx_i  (byte_idx_d),
    .byte_o (sel_byte)
  );

  // The byte for the next index is prepared ahead so tx_data is always a register.
  always_comb begin
    byte_idx_d  = byte_idx_q + IDX_W'(1);
    csum_d      = csum_q ^ tx_data_q;
    next_byte_d = sel_byte;
    if (byte_idx_d == IDX_W'(1)) begin
      next_byte_d = frame_count_q[15:8];
    end else if (byte_idx_d == IDX_W'(2)) begin
      next_byte_d = frame_count_q[7:0];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_idx_q    <= '0;
      csum_q        <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      resethist_q   <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      resethist_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_SNAP;
            resethist_q <= clear_after;
          end
        end
        S_SNAP: begin
          state_q    <= S_SEND;
          byte_idx_q <= '0;
          csum_q     <= 8'h00;
          tx_data_q  <= SYNC_BYTE;
          tx_valid_q <= 1'b1;
        end
        S_SEND: begin
          if (tx_ready) begin
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            if (byte_idx_q == LAST_IDX) begin
              state_q   <= S_CSUM;
              tx_data_q <= csum_d;
            end else begin
              tx_data_q <= next_byte_d;
            end
          end
        end
        S_CSUM: begin
          if (tx_ready) begin
            state_q       <= S_IDLE;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign resethist   = resethist_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/hist_readout.md
# hist_readout

Readout engine for the photon-timing histograms. On a host request it snapshots the per-bin photon counters and the 64-bin inter-photon-interval histogram in one cycle, optionally requests a histogram clear, and streams the snapshot as a framed, checksummed byte stream to the board's byte-wide transmit link. It sits between the photon/histogram block (reader side) and the UART/USB byte transmitter.

## Interface
Parameters:
- NBINS, 8, number of photon-bin counters (32-bit each)
- NIPI, 64, number of inter-photon-interval bins (32-bit each)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clkin  in  1  sole clock; same domain as the histogram block
- rst  in  1  synchronous, active-high reset
- start  in  1  dump request; sampled only in IDLE
- clear_after  in  1  sampled with start; 1 = pulse resethist during SNAP
- histo_in  in  32*NBINS  bin counters, bin i at [32*i+31:32*i]
- ipihist_in  in  32*NIPI  interval histogram, bin i at [32*i+31:32*i]
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state except IDLE
- resethist  out  1  one-cycle clear request to histogram block
- frame_count  out  16  completed frames since reset

## Operation
- States: IDLE, SNAP, SEND, CSUM.
- IDLE: start=1 → SNAP; latch clear_after. start while busy is ignored (not queued).
- SNAP (1 cycle): register all NBINS+NIPI inputs into snapshot array; resethist=1 this cycle iff clear_after latched; byte_idx←0, csum←0 → SEND.
- SEND: byte sequence, byte_idx 0..L-2, L = 4 + 4*(NBINS+NIPI) (292 default):
  - idx 0: SYNC_BYTE
  - idx 1: frame_count[15:8]; idx 2: frame_count[7:0] (value before this frame's increment)
  - idx 3..: histo bins 0..NBINS-1, then ipihist bins 0..NIPI-1; each word little-endian (byte 0 = [7:0])
  - on transfer (tx_valid & tx_ready): csum ^= tx_data, byte_idx++; after idx L-2 → CSUM.
- CSUM: tx_data = csum (XOR of all L-1 preceding bytes); on transfer → IDLE, frame_count++ (wraps 16'hFFFF → 0).
- Handshake: tx_valid never drops and tx_data never changes while tx_valid=1 and tx_ready=0. tx_ready while tx_valid=0 has no effect.
- Snapshot is immutable for the frame; input changes after SNAP do not appear in the stream.
- rst mid-frame: abort immediately, no checksum byte, frame_count cleared; transmitter may see a truncated frame (host resyncs on SYNC_BYTE).

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, resethist=0, frame_count=0, state IDLE.
- start at edge t → SNAP during cycle t+1 (busy=1, resethist if requested) → tx_valid=1 with SYNC_BYTE at t+2.
- Throughput: one byte per cycle with tx_ready held 1; frame occupies L cycles of SEND+CSUM; busy falls the cycle after CSUM transfer; next start accepted that cycle.
- resethist is exactly one cycle wide, never asserted outside SNAP; snapshot captures pre-clear values (clear takes effect in the histogram block ≥1 cycle later).
- No combinational path from tx_ready to tx_valid or tx_data.

## Structure
- Shared package hist_pkg: NBINS, NIPI, SYNC_BYTE, state enum, frame length constant L, 32-bit counter typedef (also used by the histogram block).
- One sub-module natural: hist_byte_sel — combinational selection of the snapshot byte for byte_idx (word = (idx-3)>>2, lane = (idx-3)&3).

## Test plan
- Default params, histo_in bin i = i+1, ipihist bin i = 32'h100+i, tx_ready=1, start pulse → 292 bytes: A5,00,00,01,00,00,00,02,…, last data bytes 3F,01,00,00, then correct XOR; frame_count=1 after.
- Same, tx_ready random 30% duty → identical byte stream; tx_data stable whenever tx_valid & !tx_ready.
- clear_after=1 → resethist high exactly one cycle, the cycle after start; inputs changed to 0 after SNAP → stream still carries pre-change values.
- start pulsed repeatedly during SEND → ignored; exactly one frame; three back-to-back frames carry counts 0,1,2.
- rst asserted at byte 100 → tx_valid=0, busy=0, frame_count=0 next cycle; following start emits full frame with count 0000.
- Force frame_count to FFFF via 65535 frames (or reduced-width build) → next frame header FF,FF, frame_count wraps to 0.
